// File: rtl/tpuv1_mm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tpuv1_mm_sequencer
// Purpose  : Sequences one matrix-multiply pass of the systolic array.
//            Decodes the host command write, drives skewed A/B feed and
//            array compute enables, pulses done, and blocks host writes
//            into the A/B/C windows while a pass is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module tpuv1_mm_sequencer #(
  parameter int unsigned       DIM      = 8,
  parameter int unsigned       ADDRW    = 16,
  parameter logic [ADDRW-1:0]  A_BASE   = 'h100,
  parameter logic [ADDRW-1:0]  C_END    = 'h400,
  parameter logic [ADDRW-1:0]  CMD_ADDR = 'h400,
  parameter int unsigned       CNTW     = $clog2(3*DIM-2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_wr,
  input  logic [ADDRW-1:0] host_addr,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             en_sa,
  output logic             en_ab,
  output logic [CNTW-1:0]  feed_idx,
  output logic             host_wr_blk,
  output logic             cmd_ovr
);

  // Last RUN count (feed plus drain) and last count that still feeds A/B.
  localparam logic [CNTW-1:0] C_RUN_LAST  = CNTW'(3*DIM-3);
  localparam logic [CNTW-1:0] C_FEED_LAST = CNTW'(2*DIM-2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            cmd_ovr_q, cmd_ovr_d;
  logic            cmd;

  assign cmd = host_wr && (host_addr == CMD_ADDR);

  // State register, pass counter and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_ovr_q <= cmd_ovr_d;
    end
  end

  // Next-state logic; a command arriving while busy is dropped but recorded,
  // and abort takes priority over both the command and the normal count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_ovr_d = cmd_ovr_q | (busy & cmd);
    case (state_q)
      S_IDLE: begin
        if (cmd) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == C_RUN_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNTW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from state; feed_idx is forced to zero outside RUN.
  always_comb begin
    busy        = (state_q != S_IDLE);
    en_sa       = (state_q == S_RUN);
    en_ab       = en_sa && (cnt_q <= C_FEED_LAST);
    feed_idx    = en_sa ? cnt_q : '0;
    done        = (state_q == S_DONE);
    host_wr_blk = busy && host_wr && (host_addr >= A_BASE) && (host_addr < C_END);
    cmd_ovr     = cmd_ovr_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_tpuv1_mm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpuv1_mm_sequencer
// Purpose  : Directed self-checking bench for tpuv1_mm_sequencer (DIM=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpuv1_mm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_wr = 1'b0;
  logic [15:0] host_addr = '0;
  logic        abort = 1'b0;
  logic        busy, done, en_sa, en_ab, host_wr_blk, cmd_ovr;
  logic [4:0]  feed_idx;

  int n_cmp = 0;
  int n_err = 0;

  tpuv1_mm_sequencer dut (
    .clk(clk), .rst(rst), .host_wr(host_wr), .host_addr(host_addr),
    .abort(abort), .busy(busy), .done(done), .en_sa(en_sa), .en_ab(en_ab),
    .feed_idx(feed_idx), .host_wr_blk(host_wr_blk), .cmd_ovr(cmd_ovr)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue a single-cycle command write; returns at cycle 1 of the pass.
  task automatic issue_cmd();
    host_wr   = 1'b1;
    host_addr = 16'h400;
    tick();
    host_wr   = 1'b0;
    host_addr = 16'h000;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if ({busy, done, en_sa, en_ab, host_wr_blk, cmd_ovr} !== 6'b0 || feed_idx !== 5'd0) begin
      n_err++;
      $display("FAIL reset_held: outs=%b idx=%0d required all 0", {busy, done, en_sa, en_ab, host_wr_blk, cmd_ovr}, feed_idx);
    end
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({busy, done, en_sa, en_ab, cmd_ovr} !== 5'b0 || feed_idx !== 5'd0) begin
      n_err++;
      $display("FAIL reset_release: outs=%b idx=%0d required all 0", {busy, done, en_sa, en_ab, cmd_ovr}, feed_idx);
    end
  endtask

  task automatic test_nominal();
    issue_cmd();
    for (int k = 1; k <= 25; k++) begin
      n_cmp++;
      if (en_sa !== (k <= 22)) begin
        n_err++;
        $display("FAIL nom_en_sa k=%0d: got %b required %b", k, en_sa, (k <= 22));
      end
      n_cmp++;
      if (en_ab !== (k <= 15)) begin
        n_err++;
        $display("FAIL nom_en_ab k=%0d: got %b required %b", k, en_ab, (k <= 15));
      end
      n_cmp++;
      if (feed_idx !== ((k <= 22) ? 5'(k - 1) : 5'd0)) begin
        n_err++;
        $display("FAIL nom_feed_idx k=%0d: got %0d required %0d", k, feed_idx, (k <= 22) ? k - 1 : 0);
      end
      n_cmp++;
      if (done !== (k == 23)) begin
        n_err++;
        $display("FAIL nom_done k=%0d: got %b required %b", k, done, (k == 23));
      end
      n_cmp++;
      if (busy !== (k <= 23)) begin
        n_err++;
        $display("FAIL nom_busy k=%0d: got %b required %b", k, busy, (k <= 23));
      end
      tick();
    end
    n_cmp++;
    if (cmd_ovr !== 1'b0) begin
      n_err++;
      $display("FAIL nom_cmd_ovr: got %b required 0", cmd_ovr);
    end
  endtask

  task automatic test_back_to_back();
    issue_cmd();
    for (int k = 1; k < 24; k++) tick();
    // k=24: first IDLE cycle after done
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle_gap: busy got %b required 0", busy);
    end
    issue_cmd();
    n_cmp++;
    if (en_sa !== 1'b1 || feed_idx !== 5'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_restart: en_sa=%b idx=%0d busy=%b required 1/0/1", en_sa, feed_idx, busy);
    end
    for (int k = 2; k <= 24; k++) begin
      tick();
      if (k == 23) begin
        n_cmp++;
        if (done !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_done: got %b required 1 at cycle 23", done);
        end
      end
    end
    n_cmp++;
    if (cmd_ovr !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_cmd_ovr: got %b required 0", cmd_ovr);
    end
  endtask

  task automatic test_host_gating();
    logic [15:0] addrs [6];
    logic        blk_busy [6];
    addrs    = '{16'h100, 16'h2F8, 16'h378, 16'h3FF, 16'h0FF, 16'h400};
    blk_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    issue_cmd();
    tick();
    for (int i = 0; i < 6; i++) begin
      host_wr   = 1'b1;
      host_addr = addrs[i];
      #1;
      n_cmp++;
      if (host_wr_blk !== blk_busy[i]) begin
        n_err++;
        $display("FAIL gate_busy addr=%h: got %b required %b", addrs[i], host_wr_blk, blk_busy[i]);
      end
    end
    host_wr   = 1'b0;
    host_addr = 16'h100;
    #1;
    n_cmp++;
    if (host_wr_blk !== 1'b0) begin
      n_err++;
      $display("FAIL gate_read: got %b required 0", host_wr_blk);
    end
    host_addr = 16'h000;
    for (int k = 2; k <= 24; k++) tick();
    for (int i = 0; i < 6; i++) begin
      host_wr   = 1'b1;
      host_addr = addrs[i];
      #1;
      n_cmp++;
      if (host_wr_blk !== 1'b0) begin
        n_err++;
        $display("FAIL gate_idle addr=%h: got %b required 0", addrs[i], host_wr_blk);
      end
    end
    host_wr   = 1'b0;
    host_addr = 16'h000;
    tick();
  endtask

  task automatic test_abort();
    int run_len;
    // abort while idle must have no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: busy got %b required 0", busy);
    end
    issue_cmd();
    for (int k = 1; k < 18; k++) tick();
    n_cmp++;
    if (feed_idx !== 5'd17) begin
      n_err++;
      $display("FAIL abort_pre_idx: got %0d required 17", feed_idx);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || en_sa !== 1'b0 || feed_idx !== 5'd0) begin
      n_err++;
      $display("FAIL abort_stop: busy=%b en_sa=%b idx=%0d required 0/0/0", busy, en_sa, feed_idx);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL abort_no_done k=%0d: got %b required 0", k, done);
      end
      tick();
    end
    issue_cmd();
    run_len = 0;
    for (int k = 0; k < 40 && en_sa === 1'b1; k++) begin
      run_len++;
      tick();
    end
    n_cmp++;
    if (run_len !== 22 || done !== 1'b1) begin
      n_err++;
      $display("FAIL abort_fresh_pass: run=%0d done=%b required 22/1", run_len, done);
    end
    tick();
  endtask

  task automatic test_overrun();
    issue_cmd();
    for (int k = 1; k <= 24; k++) begin
      if (k == 6) begin
        n_cmp++;
        if (feed_idx !== 5'd5) begin
          n_err++;
          $display("FAIL ovr_idx: got %0d required 5", feed_idx);
        end
        host_wr   = 1'b1;
        host_addr = 16'h400;
      end else begin
        host_wr   = 1'b0;
        host_addr = 16'h000;
      end
      n_cmp++;
      if (done !== (k == 23) || busy !== (k <= 23) || en_sa !== (k <= 22)) begin
        n_err++;
        $display("FAIL ovr_timing k=%0d: done=%b busy=%b en_sa=%b", k, done, busy, en_sa);
      end
      if (k >= 7) begin
        n_cmp++;
        if (cmd_ovr !== 1'b1) begin
          n_err++;
          $display("FAIL ovr_flag k=%0d: got %b required 1", k, cmd_ovr);
        end
      end
      tick();
    end
    for (int k = 0; k < 3; k++) tick();
    n_cmp++;
    if (cmd_ovr !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_sticky: cmd_ovr=%b busy=%b required 1/0", cmd_ovr, busy);
    end
  endtask

  task automatic test_midrun_reset();
    issue_cmd();
    for (int k = 1; k < 11; k++) tick();
    n_cmp++;
    if (feed_idx !== 5'd10) begin
      n_err++;
      $display("FAIL rst_pre_idx: got %0d required 10", feed_idx);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, en_sa, en_ab, done, cmd_ovr} !== 5'b0 || feed_idx !== 5'd0) begin
      n_err++;
      $display("FAIL rst_async: outs=%b idx=%0d required all 0", {busy, en_sa, en_ab, done, cmd_ovr}, feed_idx);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if ({busy, en_sa, en_ab, done, cmd_ovr} !== 5'b0) begin
        n_err++;
        $display("FAIL rst_after k=%0d: outs=%b required 0", k, {busy, en_sa, en_ab, done, cmd_ovr});
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_host_gating();
    test_abort();
    test_overrun();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tpuv1_mm_sequencer.md
Name: tpuv1_mm_sequencer

Overview:
Control FSM that sequences one matrix-multiply pass of the TPU systolic array.
- Decodes the host command write at CMD_ADDR.
- Drives the skewed A/B feed enables and the array compute enable for the required number of cycles, then pulses done.
- Blocks host writes into the A/B/C windows while a pass is in flight.
- Sits between the host address/data decode and the A/B memories plus the systolic array inside tpuv1.

Parameters:
DIM, 8, systolic array dimension; legal range DIM >= 2.
ADDRW, 16, host address width.
A_BASE, 'h100, first address of the A window (B window at 'h200, C window at 'h300).
C_END, 'h400, first address past the C window; the protected range is [A_BASE, C_END).
CMD_ADDR, 'h400, host write to this address requests a matmul.
CNTW, $clog2(3*DIM-2), cycle counter width; derived, do not override.

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  asynchronous active-high reset.
host_wr  input  1  host write strobe (r_w=1 this cycle).
host_addr  input  ADDRW  host address this cycle.
abort  input  1  synchronous cancel of an in-flight pass.
busy  output  1  high while a pass is in progress (state RUN or DONE).
done  output  1  single-cycle pulse at end of a pass.
en_sa  output  1  systolic array compute/shift enable.
en_ab  output  1  A/B skewed-feed memory shift enable.
feed_idx  output  CNTW  current cycle index within the pass.
host_wr_blk  output  1  suppresses the host write this cycle.
cmd_ovr  output  1  sticky flag: command received while busy.

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, cmd_ovr=0. All outputs are 0 while rst is high and immediately after it deasserts.
- cmd = host_wr && host_addr==CMD_ADDR. This is combinational from the inputs.
- States: IDLE, RUN, DONE. busy = (state != IDLE).
- IDLE:
  - cmd at a posedge -> RUN, cnt=0.
  - abort is ignored in IDLE.
- RUN:
  - en_sa=1.
  - en_ab=1 when cnt <= 2*DIM-2, else 0.
  - feed_idx=cnt.
  - cnt increments by 1 at each posedge.
  - At the posedge where cnt==3*DIM-3 -> DONE, cnt=0.
  - RUN therefore lasts exactly 3*DIM-2 cycles: 2*DIM-1 feed cycles plus DIM-1 drain cycles.
- DONE: lasts one cycle with done=1, en_sa=0, en_ab=0, then returns to IDLE.
- Latency: the first en_sa cycle is the cycle after the cmd edge. done is high during cycle 3*DIM-1 after the cmd edge; for DIM=8 that is cycle 23.
- Outside RUN: en_sa=0, en_ab=0, feed_idx=0.
- abort in RUN or DONE: at the posedge -> IDLE, cnt=0, and no done pulse follows.
  - abort and cmd in the same cycle while busy: abort wins and cmd_ovr is set.
  - abort in the same cycle as the DONE pulse: done is still high for that cycle, then IDLE.
- cmd while busy (RUN or DONE): the command is dropped, cmd_ovr is set at the posedge, and the pass is unaffected. cmd_ovr clears only on rst.
- cmd in IDLE in the same cycle the previous DONE exits is not possible, since DONE->IDLE is one edge. A cmd one cycle after DONE starts a new pass normally.
- host_wr_blk = busy && host_wr && A_BASE <= host_addr < C_END. This is combinational.
  - It is 0 for CMD_ADDR and for reads.
  - It is 0 in IDLE.
- Compare host_addr as unsigned.
- Counter never wraps: its max value 3*DIM-3 fits in CNTW bits.

Test Plan:
- Reset: assert rst mid-RUN at cnt=10 (DIM=8) -> busy, en_sa, en_ab, done all 0 immediately, and they stay 0 after release with no cmd.
- Nominal pass (DIM=8): single-cycle host_wr to 'h400 -> en_sa high for 22 consecutive cycles; en_ab high for the first 15 of them (feed_idx 0..14); done high exactly one cycle, 23 cycles after the cmd edge; busy high for 23 cycles.
- Overrun: second write to 'h400 at feed_idx=5 -> pass timing unchanged, done still at cycle 23, cmd_ovr=1 and it stays 1 until rst.
- Host gating: while busy, write to 'h100, 'h2F8 and 'h378 -> host_wr_blk=1; write to 'h0FF and 'h400 -> host_wr_blk=0; same writes while IDLE -> host_wr_blk=0.
- Abort: abort at feed_idx=17 -> next cycle busy=0, no done pulse; a fresh cmd afterwards gives a full 22-cycle RUN.
- Back-to-back: cmd in the first IDLE cycle after done -> new pass starts, feed_idx restarts at 0, cmd_ovr stays 0.
